alu16_sequencer: RTL
====================

Name: alu16_sequencer

Overview:
- Initiator-side controller for the alu16 bit-serial ALU.
- Accepts operation requests on a valid/ready interface and drives the ALU's on/ina/inb/op inputs.
- Watches the ALU's count output for completion, captures the 17-bit result and returns it on a valid/ready response interface.
- Sits between the instruction/control logic and alu16; replaces ad-hoc bench sequencing of the on pulse.

Parameters:
- WIDTH, 16, operand width; result is WIDTH+1 bits.
- ON_CYCLES, 2, cycles alu_on is held high per operation (1..15).
- DONE_COUNT, 4'hF, alu_count value that marks the final serial step.
- TIMEOUT_CYCLES, 64, RUN-state cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock; same clock as alu16.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  3  ALU opcode.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH+1  captured ALU result.
- rsp_op  out  3  opcode echo for the response.
- rsp_timeout  out  1  result invalid due to timeout (constant 0 when feature is absent).
- alu_on  out  1  to alu16 on.
- alu_ina  out  WIDTH  to alu16 ina.
- alu_inb  out  WIDTH  to alu16 inb.
- alu_op  out  3  to alu16 op.
- alu_count  in  4  from alu16 count.
- alu_out  in  WIDTH+1  from alu16 out.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n low): state=IDLE; req_ready=1; rsp_valid=0; rsp_result=0; rsp_op=0; rsp_timeout=0; alu_on=0; alu_ina=0; alu_inb=0; alu_op=0; busy=0; internal counters=0.
- States: IDLE, START, RUN, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register a/b/op into alu_ina/alu_inb/alu_op, go to START. alu_on rises on the next cycle.
- START: alu_on=1 for exactly ON_CYCLES cycles (on-counter counts 0..ON_CYCLES-1), then go to RUN with alu_on=0.
- RUN: alu_on=0. Operands and opcode are held stable for the whole operation.
  - Completion is the first cycle in RUN where alu_count==DONE_COUNT.
  - On the following cycle, capture alu_out into rsp_result and rsp_op=alu_op, set rsp_valid=1, go to RESP.
- RESP: rsp_valid stays high and rsp_result, rsp_op and rsp_timeout stay stable until rsp_ready. On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE; req_ready rises on the next cycle.
  - There is no request/response overlap: at most one operation is in flight.
- req_ready is 0 in START, RUN and RESP. req_valid is ignored outside IDLE.
- Latency from request accept to rsp_valid: 1 + ON_CYCLES + (cycles until alu_count==DONE_COUNT) + 1.
- rsp_ready asserted in the same cycle rsp_valid rises completes the handshake in that cycle.
- Reset mid-operation: all state is cleared immediately, alu_on drops asynchronously, and no response is produced.
- alu_count already equal to DONE_COUNT on RUN entry is treated as immediate completion. alu16 restarts its count on each on pulse, so this case does not occur with a correct alu16.

Optional Feature:
- Macro ALU_SEQ_TIMEOUT_EN.
- Defined:
  - A RUN-state cycle counter is active.
  - If TIMEOUT_CYCLES elapse in RUN without completion, go to RESP with rsp_result=0, rsp_timeout=1 and rsp_op echoed.
  - rsp_timeout clears when the response handshake completes.
- Undefined: no counter is built, rsp_timeout is tied 0, and RUN waits indefinitely.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> req_ready=1, rsp_valid=0, alu_on=0, busy=0.
- Single add: a=16'h001F, b=16'h001F, op=3'b001, rsp_ready=1; model alu counts 0..15 -> alu_on high exactly 2 cycles; rsp_result=17'h0003E, rsp_op=1; rsp_valid one cycle after count==4'hF.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_result stable, req_ready=0, a new req_valid is not accepted; the handshake then returns to IDLE.
- Back-to-back: two requests (a=16'hFFFF, b=1; then a=5, b=3) with req_valid held -> second accepted only after the first response handshake; results 17'h10000 and 17'h00008.
- Reset mid-RUN: assert rst_n low while count==7 -> alu_on=0, busy=0, no rsp_valid after release.
- With ALU_SEQ_TIMEOUT_EN: model alu holds count at 0 -> after 64 RUN cycles rsp_valid=1, rsp_timeout=1, rsp_result=0.

Source files
------------

// File: rtl/alu16_sequencer.sv
// alu16_sequencer: initiator-side controller for the alu16 bit-serial ALU.
// Takes valid/ready requests, pulses alu_on, waits for the final count
// step, captures the result and returns it on a valid/ready response.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_a, req_b, req_op       operands and opcode
//   rsp_valid/rsp_ready        response handshake
//   rsp_result, rsp_op         captured result and opcode echo
//   rsp_timeout                result invalid due to RUN timeout
//   alu_on, alu_ina/inb/op     drives alu16
//   alu_count, alu_out         observed from alu16
//   busy                       high whenever not IDLE
//
// Optional feature: define ALU_SEQ_TIMEOUT_EN to build the RUN-state
// timeout counter; otherwise rsp_timeout is tied low and RUN waits forever.

module alu16_sequencer #(
   parameter int         WIDTH          = 16,
   parameter int         ON_CYCLES      = 2,
   parameter logic [3:0] DONE_COUNT     = 4'hF,
   parameter int         TIMEOUT_CYCLES = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH:0]   rsp_result,
   output logic [2:0]       rsp_op,
   output logic             rsp_timeout,
   output logic             alu_on,
   output logic [WIDTH-1:0] alu_ina,
   output logic [WIDTH-1:0] alu_inb,
   output logic [2:0]       alu_op,
   input  logic [3:0]       alu_count,
   input  logic [WIDTH:0]   alu_out,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2,
      RESP  = 2'd3
   } state_e;

   localparam logic [3:0] ON_LAST = 4'(ON_CYCLES - 1);

   state_e           state_q;
   logic [3:0]       on_cnt_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             rsp_valid_q;
   logic [WIDTH:0]   rsp_result_q;
   logic [2:0]       rsp_op_q;
   logic             alu_on_q;
   logic [WIDTH-1:0] alu_ina_q;
   logic [WIDTH-1:0] alu_inb_q;
   logic [2:0]       alu_op_q;

`ifdef ALU_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] run_cnt_q;
   logic          timeout_q;

   assign rsp_timeout = timeout_q;
`else
   assign rsp_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         on_cnt_q     <= '0;
         req_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_op_q     <= '0;
         alu_on_q     <= 1'b0;
         alu_ina_q    <= '0;
         alu_inb_q    <= '0;
         alu_op_q     <= '0;
`ifdef ALU_SEQ_TIMEOUT_EN
         run_cnt_q    <= '0;
         timeout_q    <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  alu_ina_q   <= req_a;
                  alu_inb_q   <= req_b;
                  alu_op_q    <= req_op;
                  alu_on_q    <= 1'b1;
                  on_cnt_q    <= '0;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= START;
`ifdef ALU_SEQ_TIMEOUT_EN
                  run_cnt_q   <= '0;
`endif
               end
            end
            START: begin
               if (on_cnt_q == ON_LAST) begin
                  alu_on_q <= 1'b0;
                  on_cnt_q <= '0;
                  state_q  <= RUN;
               end else begin
                  on_cnt_q <= on_cnt_q + 4'd1;
               end
            end
            RUN: begin
               // alu_out already holds the final value on the last step
               if (alu_count == DONE_COUNT) begin
                  rsp_result_q <= alu_out;
                  rsp_op_q     <= alu_op_q;
                  rsp_valid_q  <= 1'b1;
                  state_q      <= RESP;
               end
`ifdef ALU_SEQ_TIMEOUT_EN
               else if (run_cnt_q == TO_LAST) begin
                  rsp_result_q <= '0;
                  rsp_op_q     <= alu_op_q;
                  rsp_valid_q  <= 1'b1;
                  timeout_q    <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  run_cnt_q <= run_cnt_q + TW'(1);
               end
`endif
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
`ifdef ALU_SEQ_TIMEOUT_EN
                  timeout_q   <= 1'b0;
`endif
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign busy       = busy_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_op     = rsp_op_q;
   assign alu_on     = alu_on_q;
   assign alu_ina    = alu_ina_q;
   assign alu_inb    = alu_inb_q;
   assign alu_op     = alu_op_q;

endmodule
